// File: rtl/spi_cfg_regs.sv
// SPI-slave configuration register file: frames are RW, address, data (MSB first).
// Optional MISO readback of the addressed register is compiled in with `define SPI_CFG_READBACK_EN.
module spi_cfg_regs #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 3,
  parameter int                NUM_REGS = 4,
  parameter logic [DATA_W-1:0] REG0_RST = 16'h0988
) (
  input  logic                       CLK,
  input  logic                       RSTb,
  input  logic                       SCK,
  input  logic                       CS,
  input  logic                       MOSI,
  output logic                       MISO,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       wr_stb,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int HDR_LEN   = 1 + ADDR_W;
  localparam int FRAME_LEN = HDR_LEN + DATA_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);

  localparam logic [CNT_W-1:0]  CNT_HDR   = CNT_W'(HDR_LEN);
  localparam logic [CNT_W-1:0]  CNT_FRAME = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(FRAME_LEN + 1);
  localparam logic [ADDR_W:0]   ADDR_LIM  = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HDR    = 2'd1,
    S_DATA   = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  logic             r_sck_s1, r_sck_s2, r_sck_d;
  logic             r_cs_s1, r_cs_s2, r_cs_d;
  logic             r_mosi_s1, r_mosi_s2;
  logic [1:0]       r_sync_vld;
  logic             r_cs_armed;

  state_t           r_state, w_state_next;

  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr_stb;
  logic              r_frame_err;
  logic [ADDR_W-1:0] r_wr_addr;

  logic w_sck_rise, w_cs_fall, w_cs_rise;
  logic w_clear, w_sample, w_latch_hdr, w_commit, w_abort;
  logic w_len_ok, w_addr_ok, w_accept, w_read_ok, w_reject;

  // Input synchronisers; CS stages idle high so reset looks like "not selected".
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_sck_s1   <= 1'b0;
      r_sck_s2   <= 1'b0;
      r_sck_d    <= 1'b0;
      r_cs_s1    <= 1'b1;
      r_cs_s2    <= 1'b1;
      r_cs_d     <= 1'b1;
      r_mosi_s1  <= 1'b0;
      r_mosi_s2  <= 1'b0;
      r_sync_vld <= 2'b00;
      r_cs_armed <= 1'b0;
    end else begin
      r_sck_s1   <= SCK;
      r_sck_s2   <= r_sck_s1;
      r_sck_d    <= r_sck_s2;
      r_cs_s1    <= CS;
      r_cs_s2    <= r_cs_s1;
      r_cs_d     <= r_cs_s2;
      r_mosi_s1  <= MOSI;
      r_mosi_s2  <= r_mosi_s1;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
      r_cs_armed <= r_cs_armed | (r_sync_vld[1] & r_cs_s2);
    end
  end

  // A CS still low when reset lifts is not a fresh frame start: only arm once CS is seen high.
  assign w_sck_rise = r_sck_s2 & ~r_sck_d;
  assign w_cs_fall  = ~r_cs_s2 & r_cs_d & r_cs_armed;
  assign w_cs_rise  = r_cs_s2 & ~r_cs_d;

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cs_fall) w_state_next = S_HDR;
      end
      S_HDR: begin
        if (w_cs_rise)                  w_state_next = S_IDLE;
        else if (r_bit_cnt == CNT_HDR)  w_state_next = S_DATA;
      end
      S_DATA: begin
        if (w_cs_rise) w_state_next = S_COMMIT;
      end
      S_COMMIT: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_clear     = 1'b0;
    w_sample    = 1'b0;
    w_latch_hdr = 1'b0;
    w_commit    = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_clear = w_cs_fall;
      end
      S_HDR: begin
        w_sample    = w_sck_rise & ~r_cs_s2 & ~w_cs_fall;
        w_abort     = w_cs_rise;
        w_latch_hdr = ~w_cs_rise & (r_bit_cnt == CNT_HDR);
      end
      S_DATA: begin
        w_sample = w_sck_rise & ~r_cs_s2 & ~w_cs_fall;
        w_commit = w_cs_rise;
      end
      default: begin
      end
    endcase
  end

  // Commit decision is made on the DATA->COMMIT edge so regs and wr_stb change together.
  assign w_len_ok  = (r_bit_cnt == CNT_FRAME);
  assign w_addr_ok = ({1'b0, r_addr} < ADDR_LIM);
  assign w_accept  = w_commit & w_len_ok & ~r_rw & w_addr_ok;
  assign w_read_ok = w_len_ok & r_rw & w_addr_ok;
  assign w_reject  = w_abort | (w_commit & ~w_accept & ~w_read_ok);

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_wr_stb    <= 1'b0;
      r_frame_err <= 1'b0;
      r_wr_addr   <= '0;
    end else begin
      r_wr_stb    <= w_accept;
      r_frame_err <= w_reject;
      if (w_accept) r_wr_addr <= r_addr;
      if (w_clear) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
      end else if (w_sample) begin
        r_shift <= {r_shift[DATA_W-2:0], r_mosi_s2};
        if (r_bit_cnt != CNT_SAT) r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
      if (w_latch_hdr) begin
        r_rw   <= r_shift[ADDR_W];
        r_addr <= r_shift[ADDR_W-1:0];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    localparam logic [DATA_W-1:0] RST_VAL = (gi == 0) ? REG0_RST : '0;
    logic [DATA_W-1:0] r_reg;

    always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
        r_reg <= RST_VAL;
      end else if (w_accept && (r_addr == ADDR_W'(gi))) begin
        r_reg <= r_shift;
      end
    end

    assign regs[gi*DATA_W +: DATA_W] = r_reg;
  end

  assign wr_stb    = r_wr_stb;
  assign wr_addr   = r_wr_addr;
  assign frame_err = r_frame_err;

`ifdef SPI_CFG_READBACK_EN
  logic              w_sck_fall;
  logic [DATA_W-1:0] w_rb_sel;
  logic [DATA_W-1:0] r_miso_sh;

  assign w_sck_fall = ~r_sck_s2 & r_sck_d;

  // Unimplemented addresses read back as zero.
  always_comb begin
    w_rb_sel = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (r_shift[ADDR_W-1:0] == ADDR_W'(k)) w_rb_sel = regs[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_miso_sh <= '0;
    end else if (w_latch_hdr) begin
      r_miso_sh <= r_shift[ADDR_W] ? w_rb_sel : '0;
    end else if ((r_state == S_DATA) && w_sck_fall) begin
      r_miso_sh <= {r_miso_sh[DATA_W-2:0], 1'b0};
    end
  end

  assign MISO = (r_state == S_DATA) & r_miso_sh[DATA_W-1];
`else
  assign MISO = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cfg_regs.sv
// Directed bench for spi_cfg_regs: SPI frames bit-banged at 1/16 of CLK, pulses counted on CLK negedge.
`timescale 1ns/1ps
module tb_spi_cfg_regs;

  localparam int HALF = 80;

  logic        CLK = 1'b0;
  logic        RSTb;
  logic        SCK;
  logic        CS;
  logic        MOSI;
  logic        MISO;
  logic [63:0] regs;
  logic        wr_stb;
  logic [2:0]  wr_addr;
  logic        frame_err;

  int          n_checks = 0;
  int          n_err    = 0;
  int          n_wr_stb = 0;
  int          n_ferr   = 0;
  logic [63:0] stb_regs = '0;
  logic [63:0] exp_regs;

  spi_cfg_regs dut (
    .CLK       (CLK),
    .RSTb      (RSTb),
    .SCK       (SCK),
    .CS        (CS),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .regs      (regs),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .frame_err (frame_err)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (wr_stb) begin
      n_wr_stb = n_wr_stb + 1;
      stb_regs = regs;
    end
    if (frame_err) n_ferr = n_ferr + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [31:0] bits, input int hi, input int lo, inout logic [31:0] mi);
    for (int i = hi; i >= lo; i--) begin
      MOSI = bits[i];
      #(HALF);
      SCK = 1'b1;
      #(HALF);
      mi[i] = MISO;
      SCK = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [31:0] bits, input int n, output logic [31:0] mi,
                           output int d_wr, output int d_err);
    int wr0;
    int er0;
    wr0 = n_wr_stb;
    er0 = n_ferr;
    mi  = '0;
    @(negedge CLK);
    CS = 1'b0;
    #(HALF);
    send_bits(bits, n - 1, 0, mi);
    #(HALF);
    CS = 1'b1;
    repeat (12) @(negedge CLK);
    d_wr  = n_wr_stb - wr0;
    d_err = n_ferr - er0;
  endtask

  initial begin
    logic [31:0] mi;
    int          dw;
    int          de;
    int          wr0;
    int          er0;

    CS = 1'b1; SCK = 1'b0; MOSI = 1'b0; RSTb = 1'b0;
    mi = '0;
    exp_regs = 64'h0000_0000_0000_0988;
    repeat (5) @(negedge CLK);
    check("rst_in_reset_reg0", {48'h0, regs[15:0]}, 64'h0988);
    RSTb = 1'b1;
    repeat (5) @(negedge CLK);
    check("rst_regs", regs, exp_regs);
    check("rst_wr_stb", {63'h0, wr_stb}, 64'h0);
    check("rst_frame_err", {63'h0, frame_err}, 64'h0);
    check("rst_wr_addr", {61'h0, wr_addr}, 64'h0);
    check("rst_miso", {63'h0, MISO}, 64'h0);
    check("rst_no_pulses", 64'(n_wr_stb + n_ferr), 64'h0);

    run_frame(32'({1'b0, 3'd2, 16'hA5C3}), 20, mi, dw, de);
    exp_regs[47:32] = 16'hA5C3;
    $display("txn write a=2 d=A5C3: wr_stb=%0d frame_err=%0d regs=%h", dw, de, regs);
    check("w2_stb_count", 64'(dw), 64'd1);
    check("w2_err_count", 64'(de), 64'd0);
    check("w2_wr_addr", {61'h0, wr_addr}, 64'd2);
    check("w2_regs", regs, exp_regs);
    check("w2_regs_at_stb", stb_regs, exp_regs);

    run_frame(32'({1'b0, 3'd1, 15'h1234}), 19, mi, dw, de);
    $display("txn short 19b a=1: wr_stb=%0d frame_err=%0d regs=%h", dw, de, regs);
    check("short_err_count", 64'(de), 64'd1);
    check("short_stb_count", 64'(dw), 64'd0);
    check("short_regs", regs, exp_regs);

    run_frame(32'({1'b0, 3'd1, 16'hBEEF, 1'b1}), 21, mi, dw, de);
    $display("txn long 21b a=1: wr_stb=%0d frame_err=%0d regs=%h", dw, de, regs);
    check("long_err_count", 64'(de), 64'd1);
    check("long_stb_count", 64'(dw), 64'd0);
    check("long_regs", regs, exp_regs);

    run_frame(32'({1'b0, 3'd5, 16'h1111}), 20, mi, dw, de);
    $display("txn write a=5: wr_stb=%0d frame_err=%0d regs=%h", dw, de, regs);
    check("badaddr_err_count", 64'(de), 64'd1);
    check("badaddr_stb_count", 64'(dw), 64'd0);
    check("badaddr_regs", regs, exp_regs);

    run_frame(32'h0, 2, mi, dw, de);
    $display("txn abort after 2b: wr_stb=%0d frame_err=%0d", dw, de);
    check("abort_err_count", 64'(de), 64'd1);
    check("abort_stb_count", 64'(dw), 64'd0);
    check("abort_wr_addr", {61'h0, wr_addr}, 64'd2);

    run_frame(32'({1'b0, 3'd3, 16'h00FF}), 20, mi, dw, de);
    exp_regs[63:48] = 16'h00FF;
    $display("txn write a=3 d=00FF: wr_stb=%0d frame_err=%0d regs=%h", dw, de, regs);
    check("w3_stb_count", 64'(dw), 64'd1);
    check("w3_err_count", 64'(de), 64'd0);
    check("w3_regs", regs, exp_regs);

    run_frame(32'({1'b0, 3'd1, 16'h1234}), 20, mi, dw, de);
    exp_regs[31:16] = 16'h1234;
    $display("txn write a=1 d=1234: wr_stb=%0d frame_err=%0d regs=%h", dw, de, regs);
    check("w1_stb_count", 64'(dw), 64'd1);
    check("w1_regs", regs, exp_regs);

    run_frame(32'({1'b1, 3'd1, 16'h0000}), 20, mi, dw, de);
    $display("txn read a=1: wr_stb=%0d frame_err=%0d miso=%h", dw, de, mi[16:1]);
    check("rd_stb_count", 64'(dw), 64'd0);
    check("rd_err_count", 64'(de), 64'd0);
    check("rd_regs", regs, exp_regs);
`ifdef SPI_CFG_READBACK_EN
    check("rd_miso_data", {48'h0, mi[16:1]}, 64'h1234);
`else
    check("rd_miso_tied", {32'h0, mi}, 64'h0);
`endif

    run_frame(32'({1'b0, 3'd0, 16'hCAFE}), 20, mi, dw, de);
    exp_regs[15:0] = 16'hCAFE;
    $display("txn write a=0 d=CAFE: wr_stb=%0d frame_err=%0d regs=%h", dw, de, regs);
    check("w0_regs", regs, exp_regs);

    wr0 = n_wr_stb;
    er0 = n_ferr;
    @(negedge CLK);
    CS = 1'b0;
    #(HALF);
    send_bits(32'({1'b0, 3'd0, 16'hFFFF}), 19, 10, mi);
    RSTb = 1'b0;
    repeat (3) @(negedge CLK);
    exp_regs = 64'h0000_0000_0000_0988;
    check("midrst_regs_in_reset", regs, exp_regs);
    check("midrst_wr_stb_in_reset", {63'h0, wr_stb}, 64'h0);
    RSTb = 1'b1;
    repeat (5) @(negedge CLK);
    CS = 1'b1;
    repeat (4) begin
      #(HALF); SCK = 1'b1; #(HALF); SCK = 1'b0;
    end
    repeat (12) @(negedge CLK);
    $display("txn reset mid-frame: wr_stb=%0d frame_err=%0d regs=%h", n_wr_stb - wr0, n_ferr - er0, regs);
    check("midrst_no_pulses", 64'((n_wr_stb - wr0) + (n_ferr - er0)), 64'h0);
    check("midrst_regs", regs, exp_regs);
    check("midrst_wr_addr", {61'h0, wr_addr}, 64'h0);

    run_frame(32'({1'b0, 3'd0, 16'h5A5A}), 20, mi, dw, de);
    exp_regs[15:0] = 16'h5A5A;
    $display("txn write a=0 d=5A5A after reset: wr_stb=%0d frame_err=%0d regs=%h", dw, de, regs);
    check("post_stb_count", 64'(dw), 64'd1);
    check("post_err_count", 64'(de), 64'd0);
    check("post_wr_addr", {61'h0, wr_addr}, 64'd0);
    check("post_regs", regs, exp_regs);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
